div_iter: RTL and testbench

//   Iterative signed/unsigned integer divider with valid/ready on both sides.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_iter_step.sv | 27 ++
 rtl/div_iter.sv | 170 +++++++++++++++++
 tb/tb_div_iter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// a constant-evaluable clog2, and the derivation of the CALC iteration count.
// No ports; imported by div_iter.
package div_pkg;

  // IDLE  : waiting for operands, in_ready high
  // CALC  : shift-subtract on operand magnitudes
  // FIXUP : apply result signs, register results
  // DONE  : results presented, waiting for out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of CALC cycles: each cycle retires bpc quotient bits.
  function automatic int iter_of(input int dwidth, input int bpc);
    return dwidth / bpc;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division stage: shift the next numerator bit into the partial
// remainder and subtract the divisor if it fits. Purely combinational.
// Ports: rem_in (partial remainder), num_bit (next numerator bit), divisor
//        (divisor magnitude) -> rem_out (new partial remainder), q_bit.
module div_iter_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] rem_in,
  input  logic         num_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  // rem_in is always below the divisor, so the shifted trial value stays
  // under 2^W and bit W of the difference is a clean borrow flag.
  logic [W:0] trial;
  logic [W:0] diff;

  always_comb begin
    trial   = {rem_in, num_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[W];
    rem_out = q_bit ? diff[W-1:0] : trial[W-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider, BITS_PER_CYCLE quotient bits per clock.
// Latency: accept -> out_valid after ITER+2 edges (1 edge for dbz/ovf).
// Backpressure: results held in DONE until out_ready; no new accept meanwhile.
// Ports: clk/rst (sync, active-high), ce (global hold), in_valid/in_ready with
//        in_signed, dividend, divisor; out_valid/out_ready with quotient,
//        remainder, dbz (divide by zero), ovf (signed MIN / -1).
module div_iter
  import div_pkg::*;
#(
  parameter int DWIDTH         = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic [DWIDTH-1:0] dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              dbz,
  output logic              ovf
);

  localparam int ITER = iter_of(DWIDTH, BITS_PER_CYCLE);
  localparam int CW   = clog2(ITER + 1);
  // Partial remainder carries one extra bit for the shift-in before subtract.
  localparam int W    = DWIDTH + 1;
  localparam logic [DWIDTH-1:0] MIN_VAL = {1'b1, {(DWIDTH-1){1'b0}}};

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DWIDTH-1:0] num_q;     // dividend magnitude, quotient bits shift in at the bottom
  logic [W-1:0]      rem_q;     // partial remainder
  logic [W-1:0]      dvs_q;     // divisor magnitude
  logic              neg_q_q;   // quotient must be negated in FIXUP
  logic              neg_r_q;   // remainder must be negated in FIXUP
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DWIDTH-1:0] quotient_q;
  logic [DWIDTH-1:0] remainder_q;
  logic              dbz_q;
  logic              ovf_q;

  logic [DWIDTH-1:0] mag_a;
  logic [DWIDTH-1:0] mag_b;
  logic              is_ovf;
  logic [DWIDTH-1:0] num_d;
  logic [W-1:0]      rem_d;
  logic [DWIDTH-1:0] quot_fix;
  logic [DWIDTH-1:0] rem_fix;

  logic [W-1:0]              rem_chain [0:BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign rem_chain[0] = rem_q;

  // Stage k consumes numerator bit DWIDTH-1-k; the first stage yields the
  // most significant of this cycle's quotient bits.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    div_iter_step #(.W(W)) u_step (
      .rem_in  (rem_chain[k]),
      .num_bit (num_q[DWIDTH-1-k]),
      .divisor (dvs_q),
      .rem_out (rem_chain[k+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-k])
    );
  end

  always_comb begin
    // |MIN| = 2^(DWIDTH-1) still fits an unsigned DWIDTH-bit magnitude.
    mag_a    = (in_signed && dividend[DWIDTH-1]) ? -dividend : dividend;
    mag_b    = (in_signed && divisor[DWIDTH-1])  ? -divisor  : divisor;
    is_ovf   = in_signed && (dividend == MIN_VAL) && (divisor == '1);
    num_d    = (num_q << BITS_PER_CYCLE) | DWIDTH'(q_bits);
    rem_d    = rem_chain[BITS_PER_CYCLE];
    quot_fix = neg_q_q ? -num_q : num_q;
    rem_fix  = neg_r_q ? -rem_q[DWIDTH-1:0] : rem_q[DWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            num_q      <= mag_a;
            dvs_q      <= {1'b0, mag_b};
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_q_q    <= in_signed && (dividend[DWIDTH-1] ^ divisor[DWIDTH-1]);
            neg_r_q    <= in_signed && dividend[DWIDTH-1];
            if (divisor == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
            end else if (is_ovf) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= MIN_VAL;
              remainder_q <= '0;
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= rem_d;
          num_q <= num_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_q <= FIXUP;
        end

        FIXUP: begin
          quotient_q  <= quot_fix;
          remainder_q <= rem_fix;
          dbz_q       <= 1'b0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        in_signed;
  logic        out_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  int          sel;

  logic        iv [4];
  logic        ir [4];
  logic        ov [4];
  logic        dz [4];
  logic        of [4];
  logic [7:0]  q8 [2];
  logic [7:0]  r8 [2];
  logic [15:0] q16 [2];
  logic [15:0] r16 [2];

  logic        in_ready_m;
  logic        out_valid_m;
  logic        dbz_m;
  logic        ovf_m;
  logic [15:0] q_m;
  logic [15:0] r_m;

  exp_t sb[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign iv[0] = in_valid && (sel == 0);
  assign iv[1] = in_valid && (sel == 1);
  assign iv[2] = in_valid && (sel == 2);
  assign iv[3] = in_valid && (sel == 3);

  div_iter #(.DWIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_signed(in_signed), .dividend(dividend[7:0]), .divisor(divisor[7:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .quotient(q8[0]), .remainder(r8[0]),
    .dbz(dz[0]), .ovf(of[0]));
  div_iter #(.DWIDTH(8), .BITS_PER_CYCLE(2)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_signed(in_signed), .dividend(dividend[7:0]), .divisor(divisor[7:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .quotient(q8[1]), .remainder(r8[1]),
    .dbz(dz[1]), .ovf(of[1]));
  div_iter #(.DWIDTH(16), .BITS_PER_CYCLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(ov[2]), .out_ready(out_ready), .quotient(q16[0]), .remainder(r16[0]),
    .dbz(dz[2]), .ovf(of[2]));
  div_iter #(.DWIDTH(16), .BITS_PER_CYCLE(2)) u_dut3 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(ov[3]), .out_ready(out_ready), .quotient(q16[1]), .remainder(r16[1]),
    .dbz(dz[3]), .ovf(of[3]));

  always_comb begin
    in_ready_m  = ir[sel];
    out_valid_m = ov[sel];
    dbz_m       = dz[sel];
    ovf_m       = of[sel];
    case (sel)
      0:       begin q_m = {8'h00, q8[0]}; r_m = {8'h00, r8[0]}; end
      1:       begin q_m = {8'h00, q8[1]}; r_m = {8'h00, r8[1]}; end
      2:       begin q_m = q16[0];         r_m = r16[0];         end
      default: begin q_m = q16[1];         r_m = r16[1];         end
    endcase
  end

  function automatic int dw_of(input int s);
    return (s < 2) ? 8 : 16;
  endfunction

  function automatic int iter_cfg(input int s);
    return dw_of(s) / ((s % 2 == 0) ? 1 : 2);
  endfunction

  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r,
                              input logic d, input logic o);
    exp_t e;
    e.q = q; e.r = r; e.dbz = d; e.ovf = o;
    return e;
  endfunction

  // Reference model built on the simulator's own integer division.
  function automatic exp_t model(input int dw, input bit sgn,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint mask, ua, ub, sa, sb_, q, r, half;
    mask = (64'sd1 << dw) - 1;
    half = 64'sd1 << (dw - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (ub == 0) begin
      q = mask; r = ua; e.dbz = 1'b1;
    end else if (sgn) begin
      sa  = (ua >= half) ? ua - (64'sd1 << dw) : ua;
      sb_ = (ub >= half) ? ub - (64'sd1 << dw) : ub;
      if (sa == -half && sb_ == -1) begin
        q = half; r = 0; e.ovf = 1'b1;
      end else begin
        q = sa / sb_; r = sa % sb_;
      end
    end else begin
      q = ua / ub; r = ua % ub;
    end
    e.q = 16'(q & mask);
    e.r = 16'(r & mask);
    return e;
  endfunction

  function automatic logic [15:0] pick(input int dw);
    int k;
    logic [15:0] v;
    k = $urandom_range(0, 7);
    v = 16'($urandom);
    case (k)
      0: v = 16'h0000;
      1: v = (dw == 8) ? 16'h0080 : 16'h8000;
      2: v = 16'hFFFF;
      3: v = 16'h0001;
      default: ;
    endcase
    return v;
  endfunction

  // Drive one operation, push its expectation, then collect and compare the result.
  task automatic do_txn(input string name, input bit sgn, input logic [15:0] a,
                        input logic [15:0] b, input exp_t e, input bit rand_ce,
                        input bit rand_rdy, output int lat);
    int   guard;
    bit   accepted;
    bit   done;
    exp_t x;
    lat = -1;
    in_signed = sgn; dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b0;
    accepted = 0; guard = 0;
    while (!accepted && guard < 200) begin
      ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (in_ready_m && ce) begin accepted = 1; sb.push_back(e); end
      @(negedge clk); guard++;
    end
    in_valid = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    in_signed = 1'($urandom_range(0, 1));
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL %s accept: in_ready never seen within %0d cycles", name, guard);
      ce = 1'b1;
      return;
    end
    done = 0; guard = 0;
    while (!done && guard < 400) begin
      ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid_m && lat < 0) lat = guard + 1;
      if (out_valid_m && out_ready && ce) begin
        done = 1;
        x = sb.pop_front();
        checks++;
        if (q_m !== x.q) begin errors++; $display("FAIL %s quotient: got %h want %h", name, q_m, x.q); end
        checks++;
        if (r_m !== x.r) begin errors++; $display("FAIL %s remainder: got %h want %h", name, r_m, x.r); end
        checks++;
        if (dbz_m !== x.dbz) begin errors++; $display("FAIL %s dbz: got %b want %b", name, dbz_m, x.dbz); end
        checks++;
        if (ovf_m !== x.ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", name, ovf_m, x.ovf); end
      end
      @(negedge clk); guard++;
    end
    out_ready = 1'b0; ce = 1'b1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s result: out_valid handshake missing after %0d cycles", name, guard);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 0;
    in_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready_m !== 1'b0)  begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid_m); end
    checks++; if (q_m !== 16'h0)        begin errors++; $display("FAIL reset quotient: got %h want 0", q_m); end
    checks++; if (r_m !== 16'h0)        begin errors++; $display("FAIL reset remainder: got %h want 0", r_m); end
    checks++; if (dbz_m !== 1'b0)       begin errors++; $display("FAIL reset dbz: got %b want 0", dbz_m); end
    checks++; if (ovf_m !== 1'b0)       begin errors++; $display("FAIL reset ovf: got %b want 0", ovf_m); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL reset release in_ready: got %b want 1", in_ready_m); end
  endtask

  task automatic test_unsigned();
    int lat;
    sel = 0;
    do_txn("u200div7", 1'b0, 16'd200, 16'd7, mk(16'd28, 16'd4, 1'b0, 1'b0), 1'b0, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL u200div7 latency: got %0d want 10", lat); end
    do_txn("uFFdiv10", 1'b0, 16'h00FF, 16'h0010, mk(16'h000F, 16'h000F, 1'b0, 1'b0), 1'b0, 1'b0, lat);
  endtask

  task automatic test_signed();
    int lat;
    sel = 0;
    do_txn("s-7div2", 1'b1, 16'h00F9, 16'h0002, mk(16'h00FD, 16'h00FF, 1'b0, 1'b0), 1'b0, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL s-7div2 latency: got %0d want 10", lat); end
    do_txn("s7div-2", 1'b1, 16'h0007, 16'h00FE, mk(16'h00FD, 16'h0001, 1'b0, 1'b0), 1'b0, 1'b0, lat);
    do_txn("s-7div-2", 1'b1, 16'h00F9, 16'h00FE, mk(16'h0003, 16'h00FF, 1'b0, 1'b0), 1'b0, 1'b0, lat);
    do_txn("sMINdiv1", 1'b1, 16'h0080, 16'h0001, mk(16'h0080, 16'h0000, 1'b0, 1'b0), 1'b0, 1'b0, lat);
  endtask

  task automatic test_dbz_ovf();
    int lat;
    sel = 0;
    do_txn("dbz_u", 1'b0, 16'h005A, 16'h0000, mk(16'h00FF, 16'h005A, 1'b1, 1'b0), 1'b0, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_u latency: got %0d want 1", lat); end
    do_txn("dbz_s", 1'b1, 16'h005A, 16'h0000, mk(16'h00FF, 16'h005A, 1'b1, 1'b0), 1'b0, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_s latency: got %0d want 1", lat); end
    do_txn("ovf_s", 1'b1, 16'h0080, 16'h00FF, mk(16'h0080, 16'h0000, 1'b0, 1'b1), 1'b0, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_s latency: got %0d want 1", lat); end
    do_txn("ovf_u", 1'b0, 16'h0080, 16'h00FF, mk(16'h0000, 16'h0080, 1'b0, 1'b0), 1'b0, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL ovf_u latency: got %0d want 10", lat); end
  endtask

  task automatic test_backpressure();
    int   guard;
    exp_t x;
    bit   stable_bad;
    sel = 0; ce = 1'b1; out_ready = 1'b0;
    in_signed = 1'b1; dividend = 16'h0080; divisor = 16'h00FF; in_valid = 1'b1;
    guard = 0;
    while (!in_ready_m && guard < 20) begin @(negedge clk); guard++; end
    sb.push_back(mk(16'h0080, 16'h0000, 1'b0, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid_m && guard < 20) begin @(negedge clk); guard++; end
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid_m || in_ready_m || q_m !== 16'h0080 || r_m !== 16'h0000 || ovf_m !== 1'b1)
        stable_bad = 1;
      in_valid = i[0];
      in_signed = 1'b0; dividend = 16'($urandom); divisor = 16'h0003;
      @(negedge clk);
    end
    checks++;
    if (stable_bad !== 1'b0) begin errors++; $display("FAIL bp_hold: outputs moved or in_ready high while stalled (bad=%b want 0)", stable_bad); end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid_m !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid: got %b want 1", out_valid_m); sb.delete();
    end else begin
      x = sb.pop_front();
      checks++; if (q_m !== x.q)     begin errors++; $display("FAIL bp quotient: got %h want %h", q_m, x.q); end
      checks++; if (ovf_m !== x.ovf) begin errors++; $display("FAIL bp ovf: got %b want %b", ovf_m, x.ovf); end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready_m !== 1'b1)  begin errors++; $display("FAIL bp in_ready after release: got %b want 1", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL bp out_valid after release: got %b want 0", out_valid_m); end
    checks++; if (ovf_m !== 1'b0)       begin errors++; $display("FAIL bp ovf cleared: got %b want 0", ovf_m); end
  endtask

  task automatic test_ce_hold();
    int   guard;
    bit   bad;
    exp_t x;
    sel = 0; ce = 1'b1; out_ready = 1'b0;
    in_signed = 1'b0; dividend = 16'd200; divisor = 16'd7; in_valid = 1'b1;
    guard = 0;
    while (!in_ready_m && guard < 20) begin @(negedge clk); guard++; end
    sb.push_back(mk(16'd28, 16'd4, 1'b0, 1'b0));
    @(negedge clk);
    in_valid = 1'b0; ce = 1'b0; bad = 0;
    repeat (20) begin
      if (out_valid_m || in_ready_m) bad = 1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL ce_hold calc: advanced with ce=0 (bad=%b want 0)", bad); end
    ce = 1'b1;
    guard = 0;
    while (!out_valid_m && guard < 20) begin @(negedge clk); guard++; end
    ce = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL ce_hold done: out_valid got %b want 1", out_valid_m); end
    ce = 1'b1;
    if (out_valid_m) begin
      x = sb.pop_front();
      checks++; if (q_m !== x.q) begin errors++; $display("FAIL ce_hold quotient: got %h want %h", q_m, x.q); end
      checks++; if (r_m !== x.r) begin errors++; $display("FAIL ce_hold remainder: got %h want %h", r_m, x.r); end
    end else begin
      sb.delete();
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   n;
    int   acc;
    int   t [3];
    bit   upd;
    exp_t x;
    sel = 0; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b0;
    dividend = 16'($urandom_range(0, 255)); divisor = 16'($urandom_range(1, 255));
    n = 0; acc = 0; upd = 0;
    while ((acc < 3 || sb.size() > 0) && n < 200) begin
      if (upd) begin
        dividend = 16'($urandom_range(0, 255)); divisor = 16'($urandom_range(1, 255));
        in_valid = (acc < 3);
        upd = 0;
      end
      if (in_valid && in_ready_m) begin
        sb.push_back(model(8, 1'b0, dividend, divisor));
        t[acc] = n; acc++; upd = 1;
      end
      if (out_valid_m && sb.size() > 0) begin
        x = sb.pop_front();
        checks++; if (q_m !== x.q) begin errors++; $display("FAIL b2b quotient: got %h want %h", q_m, x.q); end
        checks++; if (r_m !== x.r) begin errors++; $display("FAIL b2b remainder: got %h want %h", r_m, x.r); end
      end
      @(negedge clk); n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (acc < 3) begin
      errors++; $display("FAIL b2b accepts: got %0d want 3", acc); sb.delete();
    end else begin
      if (t[1] - t[0] !== 11) begin errors++; $display("FAIL b2b period0: got %0d want 11", t[1] - t[0]); end
      checks++;
      if (t[2] - t[1] !== 11) begin errors++; $display("FAIL b2b period1: got %0d want 11", t[2] - t[1]); end
    end
  endtask

  task automatic test_reset_midcalc();
    int  guard;
    int  lat;
    bit  stale;
    logic [15:0] a;
    logic [15:0] b;
    for (int s = 0; s < 4; s++) begin
      sel = s; ce = 1'b1; out_ready = 1'b1; in_signed = 1'b0;
      dividend = 16'($urandom); divisor = 16'($urandom_range(1, 100)); in_valid = 1'b1;
      guard = 0;
      while (!in_ready_m && guard < 50) begin @(negedge clk); guard++; end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL rst_mid%0d out_valid: got %b want 0", s, out_valid_m); end
      checks++; if (in_ready_m !== 1'b0)  begin errors++; $display("FAIL rst_mid%0d in_ready: got %b want 0", s, in_ready_m); end
      @(negedge clk);
      checks++; if (in_ready_m !== 1'b1)  begin errors++; $display("FAIL rst_mid%0d in_ready after: got %b want 1", s, in_ready_m); end
      stale = 0;
      repeat (iter_cfg(s) + 4) begin
        if (out_valid_m) stale = 1;
        @(negedge clk);
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rst_mid%0d stale out_valid: got %b want 0", s, stale); end
      a = pick(dw_of(s)); b = pick(dw_of(s));
      do_txn("rst_recover", 1'b1, a, b, model(dw_of(s), 1'b1, a, b), 1'b0, 1'b0, lat);
    end
  endtask

  task automatic test_random_sweep();
    int  lat;
    bit  sgn;
    logic [15:0] a;
    logic [15:0] b;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      for (int i = 0; i < 30; i++) begin
        sgn = 1'($urandom_range(0, 1));
        a = pick(dw_of(s)); b = pick(dw_of(s));
        do_txn("sweep", sgn, a, b, model(dw_of(s), sgn, a, b), 1'b1, 1'b1, lat);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz_ovf();
    test_backpressure();
    test_ce_hold();
    test_back_to_back();
    test_reset_midcalc();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
